poco_useq: RTL and testbench
============================

// Module: poco_useq
// PURPOSE
//  Microprogram sequencer for the poco CPU. Sits upstream of the microcode ROM.
//  Each cycle it decodes the sequencing field of the current 24-bit microword,
//  together with the IR opcode and the ALU flags, and registers the next ROM address.
//  The ROM is asynchronous: uword reflects uaddr within the same cycle.
//  Supported sequencing: next, jump, opcode dispatch, conditional branch,
//  subroutine call/return, halt.
// PARAMETERS
//  AW         8      microcode address width
//  RESET_VEC  8'h00  uaddr after reset; also the target of a RET with an empty stack
//  MAP_BASE   8'h10  base address of the opcode dispatch table
//  MAP_STRIDE 4      microwords per opcode slot in the dispatch table
//  STK_DEPTH  4      return-stack entries (1..8)
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous active-low reset (0 = clear)
//  uword    in   24  current microword from ROM; this block uses only [10:0]
//  ir_op    in   4   opcode field from IR ([7:4])
//  flag_c   in   1   carry flag from the status register
//  flag_z   in   1   zero flag from the status register
//  stall    in   1   1 = hold uaddr and the stack (RAM wait)
//  uaddr    out  AW  registered microcode ROM address
//  halted   out  1   1 = sequencer is in HALT
//  stk_err  out  1   sticky flag: stack overflow or underflow
// BEHAVIOUR
//  Reset (rst=0, asynchronous): uaddr=RESET_VEC, sp=0, halted=0, stk_err=0, state=RUN.
//  Fields: sop=uword[10:8], tgt=uword[7:0]. Next-address arithmetic is mod 2^AW.
//  States:
//   - RUN: on each edge with stall=0, uaddr <= next(sop):
//     - 000 NEXT: uaddr+1. 8'hFF wraps to 8'h00.
//     - 001 JMP: tgt.
//     - 010 MAP: MAP_BASE + ir_op*MAP_STRIDE, truncated to AW.
//     - 011 JC: flag_c ? tgt : uaddr+1.
//     - 100 JZ: flag_z ? tgt : uaddr+1.
//     - 101 CALL: push uaddr+1, then tgt.
//     - 110 RET: pop, then go to the popped address.
//     - 111 HALT: uaddr holds; halted<=1; state goes to HALT.
//   - HALT: uaddr, stack and halted all hold. Only reset leaves HALT. stall is ignored.
//  stall=1 in RUN: uaddr, sp and stack are unchanged; the microword is re-presented next cycle.
//  Priority: reset > stall > sop decode.
//  Latency: one cycle from the microword to the new uaddr. No combinational path uword->uaddr.
//  Stack boundaries:
//   - CALL with sp==STK_DEPTH: no push, stk_err<=1, jump to tgt still taken.
//   - RET with sp==0: stk_err<=1, uaddr<=RESET_VEC.
//   - stk_err clears only on reset.
//  Reset mid-call: stack contents are discarded (sp=0); no stale return is possible.
// CONFIGURATION
//  POCO_USEQ_STACK_EN defined: CALL/RET behave as above; return stack of STK_DEPTH.
//  Not defined:
//   - no stack storage; CALL behaves as JMP, RET behaves as NEXT.
//   - stk_err is tied to 0.
// TESTING
//  1. Reset, sop=NEXT for 3 cycles -> uaddr 00,01,02; halted=0, stk_err=0.
//  2. uaddr=8'hFF, sop=NEXT -> uaddr=8'h00 (wrap).
//  3. ir_op=4'h3, sop=MAP -> uaddr=8'h1C; flag_c=0 with JC tgt=8'h40 -> uaddr+1;
//     flag_c=1 -> 8'h40.
//  4. STACK_EN: CALL tgt=8'h50 at 8'h05 -> 8'h50; RET -> 8'h06. Five nested CALLs
//     -> stk_err=1 on the 5th; five RETs -> 5th goes to 8'h00.
//  5. stall=1 for 3 cycles during JMP tgt=8'h20 -> uaddr held; jump lands 1 cycle
//     after stall drops.
//  6. HALT -> halted=1, uaddr frozen 10 cycles regardless of stall/uword;
//     rst pulse mid-cycle -> uaddr=8'h00 immediately.

Source files
------------

// File: rtl/poco_useq_if.sv
// rtl/poco_useq_if.sv - microword/flag inputs and ROM address outputs of the poco sequencer
interface poco_useq_if #(
    parameter int AW = 8
);
    logic [23:0]   uword;
    logic [3:0]    ir_op;
    logic          flag_c;
    logic          flag_z;
    logic          stall;
    logic [AW-1:0] uaddr;
    logic          halted;
    logic          stk_err;

    modport master (
        output uword, ir_op, flag_c, flag_z, stall,
        input  uaddr, halted, stk_err
    );

    modport slave (
        input  uword, ir_op, flag_c, flag_z, stall,
        output uaddr, halted, stk_err
    );
endinterface

// File: rtl/poco_useq.sv
// rtl/poco_useq.sv - poco microprogram sequencer; return stack built only with POCO_USEQ_STACK_EN
module poco_useq #(
    parameter int            AW         = 8,
    parameter logic [AW-1:0] RESET_VEC  = AW'(8'h00),
    parameter logic [AW-1:0] MAP_BASE   = AW'(8'h10),
    parameter int            MAP_STRIDE = 4,
    parameter int            STK_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    poco_useq_if.slave  bus
);
    typedef enum logic [2:0] {
        SOP_NEXT = 3'd0,
        SOP_JMP  = 3'd1,
        SOP_MAP  = 3'd2,
        SOP_JC   = 3'd3,
        SOP_JZ   = 3'd4,
        SOP_CALL = 3'd5,
        SOP_RET  = 3'd6,
        SOP_HALT = 3'd7
    } sop_e;

    typedef enum logic {S_RUN, S_HALT} state_e;

    state_e        state_q;
    logic [AW-1:0] uaddr_q, uaddr_d;
    logic          halted_q;
    logic [AW-1:0] addr_inc, map_addr, tgt;
    logic          halt_req;
    logic          advance;
    sop_e          sop;
    logic          unused_uword_bits;

    assign sop               = sop_e'(bus.uword[10:8]);
    assign tgt               = AW'(bus.uword[7:0]);
    assign advance           = (state_q == S_RUN) && !bus.stall;
    assign unused_uword_bits = ^bus.uword[23:11];

`ifdef POCO_USEQ_STACK_EN
    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH_C = SPW'(STK_DEPTH);

    logic [AW-1:0]  stk_q [STK_DEPTH];
    logic [SPW-1:0] sp_q, sp_dec;
    logic           stk_err_q;
    logic           push_req, pop_req, stk_fault;

    assign sp_dec = sp_q - SPW'(1);

    // Storage needs no reset: sp_q=0 after reset makes every old entry unreachable.
    always_ff @(posedge clk) begin
        if (advance && push_req) begin
            stk_q[sp_q[IW-1:0]] <= addr_inc;
        end
    end

    assign bus.stk_err = stk_err_q;
`else
    assign bus.stk_err = 1'b0;
`endif

    always_comb begin
        addr_inc = uaddr_q + AW'(1);
        map_addr = AW'(int'(MAP_BASE) + int'(bus.ir_op) * MAP_STRIDE);
        uaddr_d  = addr_inc;
        halt_req = 1'b0;
`ifdef POCO_USEQ_STACK_EN
        push_req  = 1'b0;
        pop_req   = 1'b0;
        stk_fault = 1'b0;
`endif
        case (sop)
            SOP_NEXT: uaddr_d = addr_inc;
            SOP_JMP:  uaddr_d = tgt;
            SOP_MAP:  uaddr_d = map_addr;
            SOP_JC:   uaddr_d = bus.flag_c ? tgt : addr_inc;
            SOP_JZ:   uaddr_d = bus.flag_z ? tgt : addr_inc;
`ifdef POCO_USEQ_STACK_EN
            SOP_CALL: begin
                uaddr_d = tgt;
                if (sp_q == DEPTH_C) stk_fault = 1'b1;
                else                 push_req  = 1'b1;
            end
            SOP_RET: begin
                if (sp_q == '0) begin
                    stk_fault = 1'b1;
                    uaddr_d   = RESET_VEC;
                end else begin
                    pop_req = 1'b1;
                    uaddr_d = stk_q[sp_dec[IW-1:0]];
                end
            end
`else
            SOP_CALL: uaddr_d = tgt;
            SOP_RET:  uaddr_d = addr_inc;
`endif
            SOP_HALT: begin
                uaddr_d  = uaddr_q;
                halt_req = 1'b1;
            end
            default:  uaddr_d = addr_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            uaddr_q  <= RESET_VEC;
            halted_q <= 1'b0;
`ifdef POCO_USEQ_STACK_EN
            sp_q      <= '0;
            stk_err_q <= 1'b0;
`endif
        end else if (advance) begin
            uaddr_q <= uaddr_d;
            if (halt_req) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
            end
`ifdef POCO_USEQ_STACK_EN
            if (push_req)     sp_q <= sp_q + SPW'(1);
            else if (pop_req) sp_q <= sp_dec;
            if (stk_fault)    stk_err_q <= 1'b1;
`endif
        end
    end

    assign bus.uaddr  = uaddr_q;
    assign bus.halted = halted_q;
endmodule

// File: tb/tb_poco_useq.sv
// tb/tb_poco_useq.sv - randomized and directed bench for poco_useq against a queue-based model
module tb_poco_useq;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    poco_useq_if #(.AW(8)) bus();

    poco_useq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int m_ua;
    bit m_halted;
    bit m_err;
    int m_stk[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("uaddr", int'(bus.uaddr), m_ua);
        check("halted", int'(bus.halted), int'(m_halted));
        check("stk_err", int'(bus.stk_err), int'(m_err));
    endtask

    task automatic model_reset();
        m_ua     = 0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic [2:0] sop, input logic [7:0] tgt, input logic [3:0] op,
                              input logic c, input logic z, input logic st);
        int inc;
        inc = (m_ua + 1) % 256;
        if (m_halted || st) return;
        case (sop)
            3'd0: m_ua = inc;
            3'd1: m_ua = int'(tgt);
            3'd2: m_ua = (16 + int'(op) * 4) % 256;
            3'd3: m_ua = c ? int'(tgt) : inc;
            3'd4: m_ua = z ? int'(tgt) : inc;
`ifdef POCO_USEQ_STACK_EN
            3'd5: begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else m_stk.push_back(inc);
                m_ua = int'(tgt);
            end
            3'd6: begin
                if (m_stk.size() == 0) begin
                    m_err = 1'b1;
                    m_ua  = 0;
                end else begin
                    m_ua = m_stk.pop_back();
                end
            end
`else
            3'd5: m_ua = int'(tgt);
            3'd6: m_ua = inc;
`endif
            default: m_halted = 1'b1;
        endcase
    endtask

    // Called right after a falling edge; returns after the next falling edge with outputs checked.
    task automatic cycle(input logic [2:0] sop, input logic [7:0] tgt, input logic [3:0] op,
                         input logic c, input logic z, input logic st);
        bus.uword  = {13'($urandom), sop, tgt};
        bus.ir_op  = op;
        bus.flag_c = c;
        bus.flag_z = z;
        bus.stall  = st;
        model_step(sop, tgt, op, c, z, st);
        @(negedge clk);
        compare_all();
    endtask

    task automatic go(input logic [2:0] sop, input logic [7:0] tgt);
        cycle(sop, tgt, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("rst_uaddr", int'(bus.uaddr), 8'h00);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_stk_err", int'(bus.stk_err), 0);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        bus.uword  = 24'h0;
        bus.ir_op  = 4'h0;
        bus.flag_c = 1'b0;
        bus.flag_z = 1'b0;
        bus.stall  = 1'b0;
        model_reset();
        @(negedge clk);
        check("init_uaddr", int'(bus.uaddr), 8'h00);
        check("init_halted", int'(bus.halted), 0);
        check("init_stk_err", int'(bus.stk_err), 0);
        rst = 1'b1;

        go(3'd0, 8'h00); check("next1", int'(bus.uaddr), 8'h01);
        go(3'd0, 8'h00); check("next2", int'(bus.uaddr), 8'h02);

        go(3'd1, 8'hFF); check("jmp_ff", int'(bus.uaddr), 8'hFF);
        go(3'd0, 8'h00); check("wrap", int'(bus.uaddr), 8'h00);

        cycle(3'd2, 8'h00, 4'h3, 1'b0, 1'b0, 1'b0); check("map3", int'(bus.uaddr), 8'h1C);
        cycle(3'd3, 8'h40, 4'h0, 1'b0, 1'b0, 1'b0); check("jc_nt", int'(bus.uaddr), 8'h1D);
        cycle(3'd3, 8'h40, 4'h0, 1'b1, 1'b0, 1'b0); check("jc_t", int'(bus.uaddr), 8'h40);
        cycle(3'd4, 8'h33, 4'h0, 1'b0, 1'b1, 1'b0); check("jz_t", int'(bus.uaddr), 8'h33);
        cycle(3'd4, 8'h77, 4'h0, 1'b1, 1'b0, 1'b0); check("jz_nt", int'(bus.uaddr), 8'h34);
        cycle(3'd2, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0); check("mapF", int'(bus.uaddr), 8'h4C);

        go(3'd1, 8'h05);
`ifdef POCO_USEQ_STACK_EN
        go(3'd5, 8'h50); check("call", int'(bus.uaddr), 8'h50);
        go(3'd6, 8'h00); check("ret", int'(bus.uaddr), 8'h06);
        for (int k = 0; k < 5; k++) begin
            go(3'd5, 8'(8'h60 + k));
            if (k == 3) check("no_ovf", int'(bus.stk_err), 0);
        end
        check("ovf_err", int'(bus.stk_err), 1);
        check("ovf_jmp", int'(bus.uaddr), 8'h64);
        begin
            int exp_ret[5] = '{8'h63, 8'h62, 8'h61, 8'h07, 8'h00};
            for (int k = 0; k < 5; k++) begin
                go(3'd6, 8'h00);
                check("ret_chain", int'(bus.uaddr), exp_ret[k]);
            end
        end
        check("unf_err", int'(bus.stk_err), 1);
        do_reset();
`else
        go(3'd5, 8'h50); check("call_as_jmp", int'(bus.uaddr), 8'h50);
        go(3'd6, 8'h00); check("ret_as_next", int'(bus.uaddr), 8'h51);
        check("no_stk_err", int'(bus.stk_err), 0);
`endif

        go(3'd1, 8'h10);
        for (int k = 0; k < 3; k++) begin
            cycle(3'd1, 8'h20, 4'h0, 1'b0, 1'b0, 1'b1);
            check("stall_hold", int'(bus.uaddr), 8'h10);
        end
        go(3'd1, 8'h20); check("stall_release", int'(bus.uaddr), 8'h20);

        go(3'd1, 8'h2A);
        go(3'd7, 8'h00);
        check("halt_flag", int'(bus.halted), 1);
        for (int k = 0; k < 10; k++) begin
            cycle(3'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check("halt_hold", int'(bus.uaddr), 8'h2A);
        end
        do_reset();

        for (int i = 0; i < 800; i++) begin
            logic [2:0] sop;
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            sop = ($urandom_range(0, 99) < 3) ? 3'd7 : 3'($urandom_range(0, 6));
            cycle(sop, 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
